// File: rtl/uart_pkg.sv
// UART receiver shared types and defaults.
// Imported by the receiver top level.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Resets to 1 so an idle-high line does not look like a start bit.
module sync2 (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[0], d};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ff_q <= 2'b11;
    else        ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit midpoint qualification,
// LSB-first data capture, stop-bit check with valid/frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;

  sync2 u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_d = '0;
              state_d   = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
